div_core_arbiter: RTL and testbench

DIV_CORE_ARBITER -- requirements
Module: div_core_arbiter

---
 rtl/div_core_arbiter.sv | 171 +++++++++++++++++
 tb/tb_div_core_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_core_arbiter.sv
// Shares one unsigned divider core among NUM_REQ requesters.
// Round-robin grant, one op in flight, flush drains the core.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                discard in-flight work
//   req_valid/req_ready  per-requester op handshake
//   req_dividend, req_divisor, req_*_clz, req_divisor_is_zero
//                        per-requester operands
//   resp_valid/resp_ready per-requester result handshake
//   resp_quotient, resp_remainder  shared result bus
//   core_start, core_dividend, core_divisor, core_*_clz,
//   core_divisor_is_zero  operands and start pulse to the core
//   core_done, core_quotient, core_remainder  core completion
module div_core_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DIV_WIDTH = 32,
  parameter int CW        = $clog2(DIV_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,

  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][DIV_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ-1:0][DIV_WIDTH-1:0] req_divisor,
  input  logic [NUM_REQ-1:0][CW-1:0] req_dividend_clz,
  input  logic [NUM_REQ-1:0][CW-1:0] req_divisor_clz,
  input  logic [NUM_REQ-1:0]      req_divisor_is_zero,

  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [DIV_WIDTH-1:0]    resp_quotient,
  output logic [DIV_WIDTH-1:0]    resp_remainder,

  output logic                    core_start,
  output logic [DIV_WIDTH-1:0]    core_dividend,
  output logic [DIV_WIDTH-1:0]    core_divisor,
  output logic [CW-1:0]           core_dividend_clz,
  output logic [CW-1:0]           core_divisor_clz,
  output logic                    core_divisor_is_zero,
  input  logic                    core_done,
  input  logic [DIV_WIDTH-1:0]    core_quotient,
  input  logic [DIV_WIDTH-1:0]    core_remainder
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [GW-1:0]        last_q;
  logic [GW-1:0]        owner_q;
  logic [DIV_WIDTH-1:0] quo_q;
  logic [DIV_WIDTH-1:0] rem_q;

  logic [GW-1:0] gnt;
  logic          any_req;
  logic [GW-1:0] idx;
  logic          grant_fire;
  logic          capture;

  // Round-robin pick: scan upward starting just past last grant.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && !flush
                   && !rst && any_req;

  // Only a clean completion in BUSY loads the result.
  assign capture = (state_q == BUSY) && core_done
                && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_fire) state_d = BUSY;
      end
      BUSY: begin
        if (core_done) begin
          state_d = flush ? IDLE : RESP;
        end else if (flush) begin
          // Core cannot be aborted; wait it out.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (core_done) state_d = IDLE;
      end
      RESP: begin
        if (flush || resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    core_start = 1'b0;
    if (grant_fire) begin
      req_ready[gnt] = 1'b1;
      core_start     = 1'b1;
    end
    if ((state_q == RESP) && !rst) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  // Grant bookkeeping and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= GW'(NUM_REQ - 1);
      owner_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      if (grant_fire) begin
        last_q  <= gnt;
        owner_q <= gnt;
      end
      if (capture) begin
        quo_q <= core_quotient;
        rem_q <= core_remainder;
      end
    end
  end

  // Operands follow the current grant candidate.
  assign core_dividend        = req_dividend[gnt];
  assign core_divisor         = req_divisor[gnt];
  assign core_dividend_clz    = req_dividend_clz[gnt];
  assign core_divisor_clz     = req_divisor_clz[gnt];
  assign core_divisor_is_zero = req_divisor_is_zero[gnt];

  assign resp_quotient  = quo_q;
  assign resp_remainder = rem_q;

endmodule

// File: tb/tb_div_core_arbiter.sv
// Directed bench for div_core_arbiter.
// Bench plays the divider core and both requesters.
module tb_div_core_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N-1:0][W-1:0] req_dividend;
  logic [N-1:0][W-1:0] req_divisor;
  logic [N-1:0][CW-1:0] req_dividend_clz;
  logic [N-1:0][CW-1:0] req_divisor_clz;
  logic [N-1:0] req_divisor_is_zero;
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_ready;
  logic [W-1:0] resp_quotient;
  logic [W-1:0] resp_remainder;
  logic core_start;
  logic [W-1:0] core_dividend;
  logic [W-1:0] core_divisor;
  logic [CW-1:0] core_dividend_clz;
  logic [CW-1:0] core_divisor_clz;
  logic core_divisor_is_zero;
  logic core_done;
  logic [W-1:0] core_quotient;
  logic [W-1:0] core_remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_core_arbiter #(.NUM_REQ(N), .DIV_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .req_dividend_clz(req_dividend_clz),
    .req_divisor_clz(req_divisor_clz),
    .req_divisor_is_zero(req_divisor_is_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient),
    .resp_remainder(resp_remainder),
    .core_start(core_start),
    .core_dividend(core_dividend),
    .core_divisor(core_divisor),
    .core_dividend_clz(core_dividend_clz),
    .core_divisor_clz(core_divisor_clz),
    .core_divisor_is_zero(core_divisor_is_zero),
    .core_done(core_done),
    .core_quotient(core_quotient),
    .core_remainder(core_remainder)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        z;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [1:0] oh(input int i);
    logic [1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Divider core behaviour (what the real core returns).
  function automatic logic [31:0] mq(input logic [31:0] a,
                                     input logic [31:0] b);
    return (b == 0) ? 32'hffff_ffff : a / b;
  endfunction

  function automatic logic [31:0] mr(input logic [31:0] a,
                                     input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic issue(input int id, input logic [31:0] a,
                       input logic [31:0] b, input logic z);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_dividend[id] = a;
    req_divisor[id] = b;
    req_divisor_is_zero[id] = z;
    @(negedge clk);
    chk("grant_ready", 64'(req_ready), 64'(oh(id)));
    chk("grant_start", 64'(core_start), 64'd1);
    chk("op_dividend", 64'(core_dividend), 64'(a));
    chk("op_divisor", 64'(core_divisor), 64'(b));
    chk("op_zero", 64'(core_divisor_is_zero), 64'(z));
    chk("op_clz", 64'(core_divisor_clz),
        64'(req_divisor_clz[id]));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic complete(input logic [31:0] q,
                          input logic [31:0] r);
    core_done = 1'b1;
    core_quotient = q;
    core_remainder = r;
    @(posedge clk); #1;
    core_done = 1'b0;
    core_quotient = 32'hdead_beef;
    core_remainder = 32'hbad0_cafe;
  endtask

  task automatic handshake(input int id, input logic [31:0] q,
                           input logic [31:0] r);
    @(negedge clk);
    chk("resp_valid", 64'(resp_valid), 64'(oh(id)));
    chk("resp_q", 64'(resp_quotient), 64'(q));
    chk("resp_r", 64'(resp_remainder), 64'(r));
    resp_ready = oh(id);
    @(posedge clk); #1;
    resp_ready = '0;
    @(negedge clk);
    chk("resp_drop", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input vec_t v);
    issue(v.id, v.a, v.b, v.z);
    for (int k = 1; k < v.lat; k++) begin
      @(negedge clk);
      chk("busy_start", 64'(core_start), 64'd0);
      chk("busy_resp", 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
    end
    complete(mq(v.a, v.b), mr(v.a, v.b));
    handshake(v.id, v.q, v.r);
  endtask

  task automatic wait_grant(output int g);
    logic seen;
    seen = 1'b0;
    g = -1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (core_start) begin
        seen = 1'b1;
        g = (req_ready == 2'b10) ? 1 : 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL grant_timeout got=none want=grant");
    end
  endtask

  initial begin
    int g;
    int gi;
    int exp_g[3];
    logic [31:0] exp_q[3];

    vecs[0] = '{0, 100, 7, 1'b0, 1, 14, 2};
    vecs[1] = '{1, 1000, 33, 1'b0, 3, 30, 10};
    vecs[2] = '{0, 5, 0, 1'b1, 2, 32'hffff_ffff, 5};
    vecs[3] = '{1, 32'hffff_ffff, 1, 1'b0, 1,
                32'hffff_ffff, 0};
    vecs[4] = '{0, 7, 9, 1'b0, 4, 0, 7};

    rst = 1'b1;
    flush = 1'b0;
    req_valid = 2'b11;
    req_dividend = '0;
    req_divisor = '0;
    req_dividend_clz[0] = 5'd3;
    req_dividend_clz[1] = 5'd4;
    req_divisor_clz[0] = 5'd7;
    req_divisor_clz[1] = 5'd9;
    req_divisor_is_zero = '0;
    resp_ready = '0;
    core_done = 1'b0;
    core_quotient = '0;
    core_remainder = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_q", 64'(resp_quotient), 64'd0);
    chk("rst_r", 64'(resp_remainder), 64'd0);
    @(posedge clk); #1;

    // Table-driven single operations
    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Back-pressure on requester 1
    issue(1, 84, 4, 1'b0);
    complete(21, 0);
    req_valid[0] = 1'b1;
    req_dividend[0] = 77;
    req_divisor[0] = 7;
    resp_ready = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'd2);
      chk("bp_q", 64'(resp_quotient), 64'd21);
      chk("bp_r", 64'(resp_remainder), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_start", 64'(core_start), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = '0;
    @(negedge clk);
    chk("bp_next_start", 64'(core_start), 64'd1);
    chk("bp_next_ready", 64'(req_ready), 64'd1);
    chk("bp_next_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    complete(11, 0);
    handshake(0, 11, 0);

    // Flush in IDLE suppresses the grant
    req_valid = 2'b01;
    req_dividend[0] = 50;
    req_divisor[0] = 5;
    flush = 1'b1;
    @(negedge clk);
    chk("fidle_ready", 64'(req_ready), 64'd0);
    chk("fidle_start", 64'(core_start), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;

    // Flush in BUSY two cycles after start -> DRAIN
    issue(0, 50, 5, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = 2'b11;
    req_dividend[1] = 60;
    req_divisor[1] = 6;
    @(negedge clk);
    chk("fbusy_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("drain_ready", 64'(req_ready), 64'd0);
    chk("drain_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_hold", 64'(core_start), 64'd0);
    @(posedge clk); #1;
    core_done = 1'b1;
    core_quotient = 99;
    core_remainder = 98;
    @(negedge clk);
    chk("drain_done_rdy", 64'(req_ready), 64'd0);
    chk("drain_done_rsp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    chk("drain_exit_start", 64'(core_start), 64'd1);
    chk("drain_exit_gnt", 64'(req_ready), 64'd2);
    chk("drain_no_resp", 64'(resp_valid), 64'd0);
    chk("drain_keep_q", 64'(resp_quotient), 64'd11);
    @(posedge clk); #1;
    req_valid = '0;
    complete(10, 0);
    handshake(1, 10, 0);

    // Flush in BUSY together with core_done
    issue(0, 8, 2, 1'b0);
    flush = 1'b1;
    complete(4, 0);
    flush = 1'b0;
    @(negedge clk);
    chk("fdone_resp", 64'(resp_valid), 64'd0);
    chk("fdone_q", 64'(resp_quotient), 64'd10);
    @(posedge clk); #1;
    run_op('{1, 60, 7, 1'b0, 1, 8, 4});

    // Flush in RESP
    issue(1, 45, 6, 1'b0);
    complete(7, 3);
    @(negedge clk);
    chk("fresp_valid", 64'(resp_valid), 64'd2);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fresp_drop", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;

    // Reset in RESP, then contention 0,1,0
    issue(0, 9, 3, 1'b0);
    complete(3, 0);
    @(negedge clk);
    chk("rresp_valid", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    req_dividend[0] = 30;
    req_divisor[0] = 4;
    req_dividend[1] = 31;
    req_divisor[1] = 5;
    @(negedge clk);
    chk("rresp_rst_resp", 64'(resp_valid), 64'd0);
    chk("rresp_rst_rdy", 64'(req_ready), 64'd0);
    chk("rresp_rst_start", 64'(core_start), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
    exp_q[0] = 7; exp_q[1] = 6; exp_q[2] = 7;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'(exp_g[n]));
      if (n == 0) begin
        chk("rr_rst_resp", 64'(resp_valid), 64'd0);
        chk("rr_rst_q", 64'(resp_quotient), 64'd0);
      end
      gi = (g < 0) ? 0 : g;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_busy_start", 64'(core_start), 64'd0);
      chk("rr_busy_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      complete(mq(req_dividend[gi], req_divisor[gi]),
               mr(req_dividend[gi], req_divisor[gi]));
      @(negedge clk);
      chk("rr_resp", 64'(resp_valid), 64'(oh(exp_g[n])));
      chk("rr_q", 64'(resp_quotient), 64'(exp_q[n]));
      chk("rr_resp_start", 64'(core_start), 64'd0);
      chk("rr_resp_ready", 64'(req_ready), 64'd0);
      resp_ready = oh(gi);
      @(posedge clk); #1;
      resp_ready = '0;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
